// File: rtl/kr580_pic_pkg.sv
// Shared constants and types for the kr580 8-input priority interrupt controller.
package kr580_pic_pkg;

    localparam logic [7:0] PIC_CMD_EOI  = 8'h20;
    localparam logic [2:0] PIC_CMD_SEOI = 3'b011;
    localparam logic [7:0] RST_BASE     = 8'hC7;
    localparam logic [7:0] SPURIOUS_VEC = 8'hFF;

    localparam logic [7:0] REG_IRR = 8'd0;
    localparam logic [7:0] REG_IMR = 8'd1;
    localparam logic [7:0] REG_ISR = 8'd2;

    typedef enum logic {
        IDLE,
        ACK
    } pic_state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } pic_cand_t;

endpackage

// File: rtl/kr580_pic_sync_edge.sv
// Multi-flop synchroniser per request line followed by a rising-edge detector.
module pic_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_o
);

    // Fewer than two flops would not settle metastability, so clamp the depth.
    localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]            last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            last_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_i};
            last_q <= sync_q[DEPTH-1];
        end
    end

    assign rise_o = sync_q[DEPTH-1] & ~last_q;

endmodule

// File: rtl/kr580_pic.sv
// Fixed-priority 8-input interrupt controller feeding the kr580 intr line and
// supplying the RST n opcode during interrupt acknowledge.
module kr580_pic
    import kr580_pic_pkg::*;
#(
    parameter logic [7:0] PORT_BASE   = 8'hE0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] irq,
    input  logic [7:0] port_a,
    input  logic [7:0] port_i,
    output logic [7:0] port_o,
    input  logic       pw,
    input  logic       pr,
    input  logic       inta,
    output logic       intr,
    output logic [7:0] vector
);

    localparam logic [7:0] ADDR_IRR = PORT_BASE + REG_IRR;
    localparam logic [7:0] ADDR_IMR = PORT_BASE + REG_IMR;
    localparam logic [7:0] ADDR_ISR = PORT_BASE + REG_ISR;

    // Lowest unmasked request that no equal-or-higher in-service level blocks.
    function automatic pic_cand_t pick_cand(input logic [7:0] req,
                                            input logic [7:0] mask,
                                            input logic [7:0] svc);
        pic_cand_t c;
        logic      blocked;
        c       = '0;
        blocked = 1'b0;
        for (int n = 0; n < 8; n++) begin
            blocked = blocked | svc[n];
            if (!blocked && !c.vld && req[n] && !mask[n]) begin
                c.vld = 1'b1;
                c.idx = 3'(n);
            end
        end
        return c;
    endfunction

    pic_state_t state_q, state_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] imr_q, imr_d;
    logic [7:0] vector_q, vector_d;
    logic       intr_q, intr_d;
    logic       inta_q;
    logic       pw_q;

    logic [7:0] irq_rise;
    logic       inta_rise;
    logic       pw_rise;
    logic       wr_cmd;
    logic       wr_imr;
    logic [7:0] imr_eff;
    pic_cand_t  cand_int;
    pic_cand_t  cand_ack;

    pic_sync_edge #(
        .WIDTH      (8),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .reset  (reset),
        .async_i(irq),
        .rise_o (irq_rise)
    );

    assign inta_rise = inta & ~inta_q;
    assign pw_rise   = pw & ~pw_q;
    assign wr_cmd    = pw_rise && (port_a == ADDR_IRR);
    assign wr_imr    = pw_rise && (port_a == ADDR_IMR);

    // An acknowledge sees a mask written in the same cycle, so a request masked
    // just as the CPU answers becomes a spurious acknowledge.
    assign imr_eff  = wr_imr ? port_i : imr_q;
    assign cand_int = pick_cand(irr_q, imr_q, isr_q);
    assign cand_ack = pick_cand(irr_q, imr_eff, isr_q);

    always_comb begin
        state_d  = state_q;
        irr_d    = irr_q;
        isr_d    = isr_q;
        imr_d    = imr_eff;
        vector_d = vector_q;
        intr_d   = 1'b0;

        if (wr_cmd) begin
            if (port_i == PIC_CMD_EOI) begin
                isr_d = isr_q & (isr_q - 8'd1);
            end else if (port_i[7:5] == PIC_CMD_SEOI && port_i[4:3] == 2'b00) begin
                isr_d[port_i[2:0]] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                intr_d = cand_int.vld;
                if (inta_rise) begin
                    state_d = ACK;
                    intr_d  = 1'b0;
                    if (cand_ack.vld) begin
                        vector_d              = RST_BASE | {2'b00, cand_ack.idx, 3'b000};
                        isr_d[cand_ack.idx]   = 1'b1;
                        irr_d[cand_ack.idx]   = 1'b0;
                    end else begin
                        vector_d = SPURIOUS_VEC;
                    end
                end
            end
            ACK: begin
                if (!inta) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge on the bit being acknowledged must not be lost.
        irr_d = irr_d | irq_rise;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            irr_q    <= '0;
            isr_q    <= '0;
            imr_q    <= 8'hFF;
            vector_q <= SPURIOUS_VEC;
            intr_q   <= 1'b0;
            inta_q   <= 1'b0;
            pw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            imr_q    <= imr_d;
            vector_q <= vector_d;
            intr_q   <= intr_d;
            inta_q   <= inta;
            pw_q     <= pw;
        end
    end

    always_comb begin
        port_o = 8'hFF;
        if (pr) begin
            if (port_a == ADDR_IRR) begin
                port_o = irr_q;
            end else if (port_a == ADDR_IMR) begin
                port_o = imr_q;
            end else if (port_a == ADDR_ISR) begin
                port_o = isr_q;
            end
        end
    end

    assign intr   = intr_q;
    assign vector = vector_q;

endmodule

// File: tb/tb_kr580_pic.sv
// Bench for kr580_pic: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_kr580_pic;

    localparam logic [7:0] BASE = 8'hE0;
    localparam int         S    = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic [7:0] port_a;
    logic [7:0] port_i;
    logic [7:0] port_o;
    logic       pw;
    logic       pr;
    logic       inta;
    logic       intr;
    logic [7:0] vector;

    kr580_pic #(
        .PORT_BASE  (BASE),
        .SYNC_STAGES(S)
    ) dut (
        .clock (clock),
        .reset (reset),
        .irq   (irq),
        .port_a(port_a),
        .port_i(port_i),
        .port_o(port_o),
        .pw    (pw),
        .pr    (pr),
        .inta  (inta),
        .intr  (intr),
        .vector(vector)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0]   m_irr, m_isr, m_imr, m_vector;
    bit         m_intr, m_in_ack, m_inta_d, m_pw_d;
    bit         model_ok = 1'b0;
    logic [7:0] hist[$];

    function automatic int lowest(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic int pick(input bit [7:0] req, input bit [7:0] mask, input bit [7:0] svc);
        int lim = lowest(svc);
        for (int n = 0; n < lim; n++) if (req[n] && !mask[n]) return n;
        return -1;
    endfunction

    function automatic bit [7:0] model_read();
        if (!pr) return 8'hFF;
        if (port_a == BASE)     return m_irr;
        if (port_a == BASE + 1) return m_imr;
        if (port_a == BASE + 2) return m_isr;
        return 8'hFF;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_vector = 8'hFF;
            m_intr = 0; m_in_ack = 0; m_inta_d = 0; m_pw_d = 0;
            hist.delete();
            for (int i = 0; i <= S; i++) hist.push_back(8'h00);
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit [7:0] rise, nimr, nisr, nirr;
            bit       wr, ackev;
            int       n_ack, n_int, l;
            rise  = hist[S-1] & ~hist[S];
            wr    = pw && !m_pw_d;
            nimr  = (wr && port_a == BASE + 1) ? port_i : m_imr;
            ackev = !m_in_ack && inta && !m_inta_d;
            n_ack = pick(m_irr, nimr, m_isr);
            n_int = pick(m_irr, m_imr, m_isr);
            nisr  = m_isr;
            nirr  = m_irr;
            if (wr && port_a == BASE) begin
                if (port_i == 8'h20) begin
                    l = lowest(nisr);
                    if (l < 8) nisr[l] = 1'b0;
                end else if (port_i >= 8'h60 && port_i <= 8'h67) begin
                    nisr[port_i - 8'h60] = 1'b0;
                end
            end
            if (ackev) begin
                if (n_ack >= 0) begin
                    m_vector    = 8'hC7 + 8'(n_ack * 8);
                    nisr[n_ack] = 1'b1;
                    nirr[n_ack] = 1'b0;
                end else begin
                    m_vector = 8'hFF;
                end
            end
            nirr     = nirr | rise;
            m_intr   = !m_in_ack && !ackev && (n_int >= 0);
            m_in_ack = m_in_ack ? inta : ackev;
            m_irr    = nirr;
            m_isr    = nisr;
            m_imr    = nimr;
            m_inta_d = inta;
            m_pw_d   = pw;
            hist.push_front(irq);
            void'(hist.pop_back());
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            check("model_intr", {7'b0, intr}, {7'b0, m_intr});
            check("model_vector", vector, m_vector);
            check("model_port_o", port_o, model_read());
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_a = a; port_i = d; pw = 1'b1;
        tick();
        pw = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1; irq = 0; port_a = 0; port_i = 0; pw = 0; pr = 0; inta = 0;
        repeat (3) tick();
        reset = 0;
        pr = 1; port_a = BASE + 1;
        @(negedge clock);
        check("imr_after_reset", port_o, 8'hFF);
        check("intr_after_reset", {7'b0, intr}, 8'h00);
        check("vector_after_reset", vector, 8'hFF);

        // irq3 latency and first acknowledge
        wr(BASE + 1, 8'h00);
        irq = 8'h08; tick();
        tick();
        pr = 1; port_a = BASE; tick();
        @(negedge clock);
        check("irr_at_k2", port_o, 8'h08);
        check("intr_low_at_k2", {7'b0, intr}, 8'h00);
        tick();
        @(negedge clock);
        check("intr_at_k3", {7'b0, intr}, 8'h01);
        port_a = BASE + 2; inta = 1; tick();
        @(negedge clock);
        check("vec_irq3", vector, 8'hDF);
        check("isr_irq3", port_o, 8'h08);
        check("intr_in_ack", {7'b0, intr}, 8'h00);
        port_a = BASE;
        @(negedge clock);
        check("irr_after_ack3", port_o, 8'h00);
        inta = 0; tick();
        wr(BASE, 8'h20);
        port_a = BASE + 2;
        @(negedge clock);
        check("isr_after_eoi", port_o, 8'h00);

        // nesting: irq3 in service, irq5 waits, irq1 preempts
        irq = 0; repeat (2) tick();
        irq = 8'h08; repeat (4) tick();
        @(negedge clock);
        check("irq3_again_intr", {7'b0, intr}, 8'h01);
        inta = 1; tick(); inta = 0; tick();
        irq = 8'h28; repeat (5) tick();
        @(negedge clock);
        check("irq5_blocked", {7'b0, intr}, 8'h00);
        irq = 8'h2A; repeat (4) tick();
        @(negedge clock);
        check("irq1_intr", {7'b0, intr}, 8'h01);
        port_a = BASE + 2; inta = 1; tick();
        @(negedge clock);
        check("vec_irq1", vector, 8'hCF);
        check("isr_nested", port_o, 8'h0A);
        inta = 0; tick();
        wr(BASE, 8'h61);
        port_a = BASE + 2;
        @(negedge clock);
        check("isr_after_seoi", port_o, 8'h08);
        tick();
        @(negedge clock);
        check("irq5_still_blocked", {7'b0, intr}, 8'h00);
        wr(BASE, 8'h20); tick();
        @(negedge clock);
        check("irq5_released", {7'b0, intr}, 8'h01);
        inta = 1; tick();
        @(negedge clock);
        check("vec_irq5", vector, 8'hEF);
        inta = 0; tick();
        wr(BASE, 8'h20);
        irq = 0;

        // spurious: mask written in the same cycle as the acknowledge edge
        irq = 8'h04; repeat (4) tick();
        @(negedge clock);
        check("irq2_intr", {7'b0, intr}, 8'h01);
        port_a = BASE + 1; port_i = 8'h04; pw = 1; inta = 1; tick();
        pw = 0; port_a = BASE + 2;
        @(negedge clock);
        check("spurious_vec", vector, 8'hFF);
        check("spurious_isr", port_o, 8'h00);
        inta = 0; port_a = BASE; tick();
        @(negedge clock);
        check("irr2_kept", port_o, 8'h04);
        wr(BASE + 1, 8'h00); tick();
        inta = 1; tick();
        @(negedge clock);
        check("vec_irq2_late", vector, 8'hD7);
        inta = 0; tick();
        wr(BASE, 8'h20);
        irq = 0;

        // held level on irq0 triggers exactly once
        irq = 8'h01; repeat (4) tick();
        inta = 1; tick();
        @(negedge clock);
        check("vec_irq0", vector, 8'hC7);
        inta = 0; tick();
        wr(BASE, 8'h20); repeat (4) tick();
        @(negedge clock);
        check("irq0_no_retrig_irr", port_o, 8'h00);
        check("irq0_no_retrig_intr", {7'b0, intr}, 8'h00);
        inta = 1; tick();
        @(negedge clock);
        check("irq0_second_ack_spurious", vector, 8'hFF);
        inta = 0; tick();
        wr(BASE, 8'h20); repeat (3) tick();
        @(negedge clock);
        check("irq0_still_quiet", {7'b0, intr}, 8'h00);

        // reset during acknowledge
        irq = 0; repeat (2) tick();
        irq = 8'h01; repeat (4) tick();
        inta = 1; port_a = BASE + 2; tick();
        @(negedge clock);
        check("isr_before_reset", port_o, 8'h01);
        reset = 1; irq = 0; tick();
        @(negedge clock);
        check("reset_intr", {7'b0, intr}, 8'h00);
        check("reset_vector", vector, 8'hFF);
        check("reset_isr", port_o, 8'h00);
        port_a = BASE;
        @(negedge clock);
        check("reset_irr", port_o, 8'h00);
        port_a = BASE + 1;
        @(negedge clock);
        check("reset_imr", port_o, 8'hFF);
        inta = 0; reset = 0; tick();
        wr(BASE + 1, 8'h00);

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(0, 7);
                irq[b] = ~irq[b];
            end
            if (inta) begin
                if ($urandom_range(0, 2) == 0) inta = 0;
            end else if (intr && $urandom_range(0, 1) == 0) begin
                inta = 1;
            end else if ($urandom_range(0, 63) == 0) begin
                inta = 1;
            end
            if (pw) begin
                if ($urandom_range(0, 3) != 0) pw = 0;
            end else if ($urandom_range(0, 4) == 0) begin
                port_a = BASE + 8'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0, 1:    port_i = 8'h20;
                    2:       port_i = 8'h60 + 8'($urandom_range(0, 7));
                    3:       port_i = 8'($urandom);
                    default: port_i = 8'($urandom & $urandom);
                endcase
                pw = 1;
            end
            if (!pw) begin
                pr     = ($urandom_range(0, 3) != 0);
                port_a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 3));
            end
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end

        reset = 0; pw = 0; inta = 0; irq = 0;
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
